img_frame_sequencer: RTL and testbench
======================================

Name: img_frame_sequencer

Overview:
- Frame-level controller that sequences one image frame into the mean-filter pipeline (mean_filter_proc) per start command.
- Reads pixels in raster order from a frame-buffer RAM (1-cycle read latency) and drives the filter's per_img_vsync/per_img_href/per_img_gray inputs with programmable vertical and horizontal blanking.
- Replaces behavioural stimulus with synthesizable sequencing; reports busy and frame-done to the host.

Parameters:
IMG_HDISP, 640, active pixels per row
IMG_VDISP, 480, active rows per frame
V_PRE, 5, cycles of vsync-high before first row blanking
H_BLANK, 5, idle (href low) cycles before each row's active pixels
V_POST, 1, cycles of vsync-high after last active pixel
ADDR_W, $clog2(IMG_HDISP*IMG_VDISP), frame-buffer address width

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; asynchronous, active-high
start  in  1  single-cycle frame request; sampled only in IDLE
abort  in  1  terminate current frame
mem_rd_en  out  1  frame-buffer read strobe
mem_rd_addr  out  ADDR_W  raster address row*IMG_HDISP+col
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
per_img_vsync  out  1  frame valid to filter
per_img_href  out  1  pixel valid to filter
per_img_gray  out  8  pixel value to filter
busy  out  1  high from cycle after accepted start until done
frame_done  out  1  one-cycle pulse at end of frame or abort

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; counters 0.
- FSM states: IDLE, VPRE, HBLANK, ACTIVE, VPOST.
- IDLE: start=1 moves to VPRE next cycle, clears row/col/addr counters. start in any other state is ignored (no queuing).
- VPRE: V_PRE cycles, then HBLANK.
- HBLANK: H_BLANK cycles, then ACTIVE. H_BLANK=0 passes straight to ACTIVE.
- ACTIVE: IMG_HDISP cycles. Each cycle asserts mem_rd_en and drives mem_rd_addr, incrementing by 1.
  - End of row, row < IMG_VDISP-1: go to HBLANK, row+1.
  - End of last row: go to VPOST.
- VPOST: V_POST cycles, then IDLE.
- Internal vsync_i is high in VPRE/HBLANK/ACTIVE/VPOST. Internal href_i equals ACTIVE.
- Output pipeline: per_img_vsync and per_img_href are vsync_i and href_i registered once. per_img_gray is registered mem_rd_data captured when href_i was high; it holds its last value when href is low.
  - Latency: mem_rd_en at cycle t gives per_img_href=1 with the matching pixel at t+1.
- busy is high in all non-IDLE states and during the one-cycle output drain.
- frame_done pulses in the first cycle per_img_vsync is low after a frame.
- abort (any non-IDLE state): next state IDLE; mem_rd_en drops in the same cycle (combinational gate); per_img_vsync/href fall next cycle; frame_done pulses. Abort in IDLE has no effect.
  - Simultaneous start+abort in IDLE: start wins.
- Address: mem_rd_addr never exceeds IMG_HDISP*IMG_VDISP-1 and returns to 0 on each new frame (no wrap within a frame).
- Counters sized by $clog2 of their maximum values. Zero-valued V_PRE/V_POST are legal and skip the state.

Decomposition:
- Package img_seq_pkg:
  - state enum (IDLE, VPRE, HBLANK, ACTIVE, VPOST)
  - pixel width constant PIX_W=8
  - function for address width
- Single module, no sub-module. The output alignment register stage is inline.

Test Plan (IMG_HDISP=4, IMG_VDISP=3, V_PRE=3, H_BLANK=2, V_POST=1; RAM preloaded with addr value):
- Reset mid-frame (rst at cycle 12) -> all outputs 0 immediately (async); next start gives a clean frame from addr 0.
- start at cycle 0 -> per_img_vsync high cycles 2..23 (22 cycles); frame_done at cycle 24; busy high cycles 1..24.
- Same frame -> per_img_href high cycles 7-10, 13-16, 19-22; per_img_gray = 0..3, 4..7, 8..11; mem_rd_addr 0..11, never 12.
- start repeated at cycle 10 during a frame -> ignored; exactly 12 href pixels; single frame_done.
- abort at cycle 14 -> mem_rd_en 0 at cycle 14; vsync/href 0 at cycle 15; frame_done at 15; next start reads from addr 0.
- Chain into mean_filter_proc with 640x480 defaults -> filter output matches golden averaged image with zero mismatches.

Source files
------------

// File: rtl/img_seq_pkg.sv
// img_seq_pkg: shared state encoding, pixel width and address-width helper for the frame sequencer.
package img_seq_pkg;
  typedef enum logic [2:0] {IDLE, VPRE, HBLANK, ACTIVE, VPOST} state_t;
  localparam int PIX_W = 8;
  function automatic int addr_w(input int h, input int v);
    return (h * v > 1) ? $clog2(h * v) : 1;
  endfunction
endpackage

// File: rtl/img_frame_sequencer.sv
// img_frame_sequencer: streams one frame from a 1-cycle-latency frame buffer into the mean filter
// with programmable vertical/horizontal blanking, per start command.
module img_frame_sequencer
  import img_seq_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int V_PRE     = 5,
  parameter int H_BLANK   = 5,
  parameter int V_POST    = 1,
  parameter int ADDR_W    = addr_w(IMG_HDISP, IMG_VDISP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              per_img_vsync,
  output logic              per_img_href,
  output logic [PIX_W-1:0]  per_img_gray,
  output logic              busy,
  output logic              frame_done
);
  localparam int PMAX = (V_PRE > H_BLANK) ? ((V_PRE > V_POST) ? V_PRE : V_POST)
                                          : ((H_BLANK > V_POST) ? H_BLANK : V_POST);
  localparam int CW  = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int CXW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int RW  = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam state_t AFTER_VPRE = (H_BLANK > 0) ? HBLANK : ACTIVE;
  localparam state_t AFTER_LAST = (V_POST > 0) ? VPOST : IDLE;
  localparam state_t AFTER_IDLE = (V_PRE > 0) ? VPRE : AFTER_VPRE;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CXW-1:0]   col;
  logic [RW-1:0]    row;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0] gray_q;
  logic             vsync_i, href_i, last_col, last_row;

  // abort gates the strobes combinationally so no read is issued in the abort cycle
  assign vsync_i     = (state != IDLE) && !abort;
  assign href_i      = (state == ACTIVE) && !abort;
  assign mem_rd_en   = href_i;
  assign mem_rd_addr = addr;
  assign last_col    = col == CXW'(IMG_HDISP - 1);
  assign last_row    = row == RW'(IMG_VDISP - 1);
  // the RAM output is already the registered pixel aligned with per_img_href; gray_q holds it between rows
  assign per_img_gray = per_img_href ? mem_rd_data : gray_q;
  assign busy         = (state != IDLE) || per_img_vsync || frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      col           <= '0;
      row           <= '0;
      addr          <= '0;
      gray_q        <= '0;
      per_img_vsync <= 1'b0;
      per_img_href  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      per_img_vsync <= vsync_i;
      per_img_href  <= href_i;
      frame_done    <= per_img_vsync && !vsync_i;
      if (per_img_href) gray_q <= mem_rd_data;
      if (state != IDLE && abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= AFTER_IDLE;
            cnt   <= '0;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
          end
          VPRE: begin
            cnt   <= (cnt == CW'(V_PRE - 1)) ? '0 : cnt + 1'b1;
            state <= (cnt == CW'(V_PRE - 1)) ? AFTER_VPRE : VPRE;
          end
          HBLANK: begin
            cnt   <= (cnt == CW'(H_BLANK - 1)) ? '0 : cnt + 1'b1;
            state <= (cnt == CW'(H_BLANK - 1)) ? ACTIVE : HBLANK;
          end
          ACTIVE: begin
            col   <= last_col ? '0 : col + 1'b1;
            row   <= (last_col && !last_row) ? row + 1'b1 : row;
            addr  <= (last_col && last_row) ? addr : addr + 1'b1;
            state <= !last_col ? ACTIVE : last_row ? AFTER_LAST : AFTER_VPRE;
          end
          VPOST: begin
            cnt   <= (cnt == CW'(V_POST - 1)) ? '0 : cnt + 1'b1;
            state <= (cnt == CW'(V_POST - 1)) ? IDLE : VPOST;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_img_frame_sequencer.sv
// tb_img_frame_sequencer: directed frames (normal, ignored restart, abort, async reset) on a 4x3 image
// with a scoreboard of expected pixels against an address-valued frame buffer.
module tb_img_frame_sequencer;
  localparam int HD = 4, VD = 3, VPR = 3, HB = 2, VPO = 1, AW = 4;
  logic clk = 1'b0, rst, start, abort;
  logic mem_rd_en, per_img_vsync, per_img_href, busy, frame_done;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0] mem_rd_data = 8'd0, per_img_gray;
  int n_cmp = 0, n_err = 0;
  int q[$];

  img_frame_sequencer #(.IMG_HDISP(HD), .IMG_VDISP(VD), .V_PRE(VPR), .H_BLANK(HB), .V_POST(VPO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 8'(mem_rd_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cycle c counted from the cycle start is driven; row r reads in cycles 6+6r .. 9+6r
  function automatic bit exp_rd(input int c);
    return c >= 6 && c <= 21 && ((c - 6) % 6) < 4;
  endfunction

  task automatic frame(input int ab, input int rc);
    int href_n = 0, done_n = 0, p;
    q.delete();
    for (int i = 0; i < HD * VD; i++) q.push_back(i);
    for (int c = 0; c < 28; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      start = (c == 0 || c == 10);
      abort = (c == ab);
      if (c == rc) begin
        rst = 1'b1;
        #1;
        chk("rst_vsync", per_img_vsync, 0);
        chk("rst_href", per_img_href, 0);
        chk("rst_gray", per_img_gray, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      if (c < ab) begin
        chk($sformatf("vsync@%0d", c), per_img_vsync, (c >= 2 && c <= 23));
        chk($sformatf("href@%0d", c), per_img_href, exp_rd(c - 1));
        chk($sformatf("rd_en@%0d", c), mem_rd_en, exp_rd(c));
        chk($sformatf("busy@%0d", c), busy, (c >= 1 && c <= 24));
        chk($sformatf("done@%0d", c), frame_done, (c == 24));
        if (exp_rd(c)) chk($sformatf("addr@%0d", c), mem_rd_addr, ((c - 6) / 6) * HD + (c - 6) % 6);
        if (c == 11) chk("gray_hold", per_img_gray, 3);
      end else if (c == ab) begin
        chk("abort_rd_en", mem_rd_en, 0);
      end else if (c == ab + 1) begin
        chk("abort_vsync", per_img_vsync, 0);
        chk("abort_href", per_img_href, 0);
        chk("abort_done", frame_done, 1);
        chk("abort_busy", busy, 1);
      end else begin
        chk($sformatf("post_abort_busy@%0d", c), busy, 0);
      end
      if (per_img_href) begin
        href_n++;
        if (q.size() == 0) chk("sb_underflow", per_img_gray, 'x);
        else begin
          p = q.pop_front();
          chk($sformatf("gray@%0d", c), per_img_gray, p);
        end
      end
      if (frame_done) done_n++;
    end
    start = 1'b0;
    abort = 1'b0;
    if (ab > 27) begin
      chk("href_count", href_n, HD * VD);
      chk("sb_left", q.size(), 0);
    end
    chk("done_count", done_n, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("init_vsync", per_img_vsync, 0);
    chk("init_busy", busy, 0);
    chk("init_rd_en", mem_rd_en, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    frame(99, 99);
    frame(14, 99);
    frame(99, 12);
    frame(99, 99);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
